// File: rtl/mdu_pkg.sv
// Shared multiply/divide op encoding and E-stage MDU controller types.
package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  function automatic logic is_md_arith(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_md_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational 64-bit product / quotient-remainder generator.
// A zero divisor passes the current HI/LO through so the commit leaves them unchanged.
module e_mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [63:0] prod_s, prod_u;
  logic        sgn;
  logic [31:0] mag_a, mag_b, q_mag, r_mag, q, r;

  // Sign-extended operands give the signed product in the low 64 bits.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide via magnitudes: quotient truncates toward zero,
  // remainder takes the dividend's sign.
  assign sgn   = (op == MD_DIV);
  assign mag_a = (sgn && a[31]) ? -a : a;
  assign mag_b = (sgn && b[31]) ? -b : b;
  assign q_mag = (b == 32'd0) ? 32'd0 : mag_a / mag_b;
  assign r_mag = (b == 32'd0) ? 32'd0 : mag_a % mag_b;
  assign q     = (sgn && (a[31] ^ b[31])) ? -q_mag : q_mag;
  assign r     = (sgn && a[31]) ? -r_mag : r_mag;

  always_comb begin
    hi = hi_in;
    lo = lo_in;
    case (op)
      MD_MULT:  {hi, lo} = prod_s;
      MD_MULTU: {hi, lo} = prod_u;
      MD_DIV, MD_DIVU: begin
        if (b != 32'd0) begin
          hi = r;
          lo = q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide controller: owns HI/LO, runs a fixed busy window
// per operation and requests a D-stage stall for MD instructions meanwhile.
module e_mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MD_Op,
  input  logic [31:0] E_SrcA,
  input  logic [31:0] E_SrcB,
  input  logic        D_Is_MD,
  output logic        MD_Busy,
  output logic        MD_Stall,
  output logic [31:0] MD_Result,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  md_state_t   state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0] p_hi, p_lo, ar_hi, ar_lo;
  logic        start;

  assign start = is_md_arith(E_MD_Op) && (state == MD_IDLE);

  e_mdu_arith u_arith (
    .op    (E_MD_Op),
    .a     (E_SrcA),
    .b     (E_SrcB),
    .hi_in (HI),
    .lo_in (LO),
    .hi    (ar_hi),
    .lo    (ar_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MD_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      MD_IDLE: if (start)      state_nx = MD_BUSY;
      MD_BUSY: if (cnt == CW'(1)) state_nx = MD_IDLE;
      default: state_nx = MD_IDLE;
    endcase
  end

  always_comb begin
    MD_Busy   = (state == MD_BUSY);
    MD_Stall  = D_Is_MD && (start || MD_Busy);
    MD_Result = 32'd0;
    if (E_MD_Op == MD_MFHI)      MD_Result = HI;
    else if (E_MD_Op == MD_MFLO) MD_Result = LO;
  end

  // Result is computed at start and parked in the shadow regs; HI/LO stay
  // architecturally stable until the last busy cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      p_hi <= '0;
      p_lo <= '0;
      HI   <= '0;
      LO   <= '0;
    end else if (state == MD_IDLE) begin
      if (start) begin
        cnt  <= is_md_div(E_MD_Op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        p_hi <= ar_hi;
        p_lo <= ar_lo;
      end else if (E_MD_Op == MD_MTHI) begin
        HI <= E_SrcA;
      end else if (E_MD_Op == MD_MTLO) begin
        LO <= E_SrcA;
      end
    end else begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        HI <= p_hi;
        LO <= p_lo;
      end
    end
  end

endmodule
